// File: rtl/inst_dec_pkg.sv
// rtl/inst_dec_pkg.sv - shared opcode, field and immediate helpers for the 16-bit RISC decoder
//
// Purpose: opcode encodings, instruction field positions and the imm_sel bit
//          index, plus sign-extension helpers used by the decoder and the ALU.
// Ports:   none (package).

package inst_dec_pkg;

  // Opcodes (I_Inst[15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_SYS  = 4'hF;

  // Instruction field positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

  // Position of imm_sel inside the 5-bit ALU operation code
  localparam int IMM_SEL = 4;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/inst_dec_imm_gen.sv
// rtl/inst_dec_imm_gen.sv - immediate generator for the instruction decoder
//
// Purpose: combinationally forms the 16-bit immediate from the opcode and the
//          instruction word.
// Ports:
//   inst_i  in  16  instruction word
//   imm_o   out 16  decoded immediate (0 for register-only opcodes)

module inst_dec_imm_gen
  import inst_dec_pkg::*;
(
  input  logic [15:0] inst_i,
  output logic [15:0] imm_o
);

  logic [3:0] op;

  assign op = inst_i[OP_MSB:OP_LSB];

  always_comb begin
    imm_o = 16'h0000;
    case (op)
      OP_ADDI, OP_LDI: imm_o = sext8(inst_i[7:0]);
      OP_LUI:          imm_o = {inst_i[7:0], 8'h00};
      OP_LD, OP_ST:    imm_o = sext4(inst_i[3:0]);
      OP_JMP:          imm_o = sext12(inst_i[11:0]);
      default:         imm_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/inst_dec.sv
// rtl/inst_dec.sv - registered instruction decoder for the 16-bit RISC core
//
// Purpose: splits an instruction word into register selects, ALU op, immediate
//          and write enable; outputs are registered and hold while disabled.
// Ports:
//   I_Clk    in  1   clock, rising edge
//   I_Rst    in  1   synchronous active-high reset (wins over I_En)
//   I_En     in  1   decode enable; outputs hold when low
//   I_Inst   in  16  instruction word
//   O_Aluop  out 5   {imm_sel, opcode}
//   O_SelA   out 4   register read port A index
//   O_SelB   out 4   register read port B index
//   O_SelD   out 4   destination register index
//   O_Imm    out 16  decoded immediate
//   O_Regwe  out 1   destination write enable

module inst_dec
  import inst_dec_pkg::*;
(
  input  logic        I_Clk,
  input  logic        I_Rst,
  input  logic        I_En,
  input  logic [15:0] I_Inst,
  output logic [4:0]  O_Aluop,
  output logic [3:0]  O_SelA,
  output logic [3:0]  O_SelB,
  output logic [3:0]  O_SelD,
  output logic [15:0] O_Imm,
  output logic        O_Regwe
);

  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  ra;
  logic [3:0]  rb;

  logic        imm_sel_d;
  logic [4:0]  aluop_d,  aluop_q;
  logic [3:0]  sela_d,   sela_q;
  logic [3:0]  selb_d,   selb_q;
  logic [3:0]  seld_d,   seld_q;
  logic [15:0] imm_d,    imm_q;
  logic        regwe_d,  regwe_q;

  assign op = I_Inst[OP_MSB:OP_LSB];
  assign rd = I_Inst[RD_MSB:RD_LSB];
  assign ra = I_Inst[RA_MSB:RA_LSB];
  assign rb = I_Inst[RB_MSB:RB_LSB];

  inst_dec_imm_gen u_imm_gen (
    .inst_i (I_Inst),
    .imm_o  (imm_d)
  );

  // Field decode: start from the register-register defaults and apply
  // only the per-opcode overrides.
  always_comb begin
    imm_sel_d = 1'b0;
    regwe_d   = 1'b1;
    seld_d    = rd;
    sela_d    = ra;
    selb_d    = rb;
    case (op)
      OP_NOT:  selb_d = 4'h0;
      OP_ADDI: begin
        sela_d    = rd;
        imm_sel_d = 1'b1;
      end
      OP_LDI, OP_LUI, OP_LD: imm_sel_d = 1'b1;
      OP_ST: begin
        // Store reads the data register through port B.
        selb_d    = rd;
        imm_sel_d = 1'b1;
        regwe_d   = 1'b0;
      end
      OP_JMP: begin
        imm_sel_d = 1'b1;
        regwe_d   = 1'b0;
      end
      OP_SYS:  regwe_d = 1'b0;
      default: ;
    endcase
    aluop_d          = 5'd0;
    aluop_d[3:0]     = op;
    aluop_d[IMM_SEL] = imm_sel_d;
  end

  always_ff @(posedge I_Clk) begin
    if (I_Rst) begin
      aluop_q <= 5'd0;
      sela_q  <= 4'd0;
      selb_q  <= 4'd0;
      seld_q  <= 4'd0;
      imm_q   <= 16'd0;
      regwe_q <= 1'b0;
    end else if (I_En) begin
      aluop_q <= aluop_d;
      sela_q  <= sela_d;
      selb_q  <= selb_d;
      seld_q  <= seld_d;
      imm_q   <= imm_d;
      regwe_q <= regwe_d;
    end
  end

  assign O_Aluop = aluop_q;
  assign O_SelA  = sela_q;
  assign O_SelB  = selb_q;
  assign O_SelD  = seld_q;
  assign O_Imm   = imm_q;
  assign O_Regwe = regwe_q;

endmodule

// File: tb/tb_inst_dec.sv
// tb/tb_inst_dec.sv - self-checking bench for inst_dec

module tb_inst_dec;

  logic        I_Clk = 1'b0;
  logic        I_Rst;
  logic        I_En;
  logic [15:0] I_Inst;
  logic [4:0]  O_Aluop;
  logic [3:0]  O_SelA;
  logic [3:0]  O_SelB;
  logic [3:0]  O_SelD;
  logic [15:0] O_Imm;
  logic        O_Regwe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  e_aluop;
  logic [3:0]  e_sela, e_selb, e_seld;
  logic [15:0] e_imm;
  logic        e_regwe;

  inst_dec dut (
    .I_Clk   (I_Clk),
    .I_Rst   (I_Rst),
    .I_En    (I_En),
    .I_Inst  (I_Inst),
    .O_Aluop (O_Aluop),
    .O_SelA  (O_SelA),
    .O_SelB  (O_SelB),
    .O_SelD  (O_SelD),
    .O_Imm   (O_Imm),
    .O_Regwe (O_Regwe)
  );

  always #5 I_Clk = ~I_Clk;

  // Two's-complement sign extension of a width-bit field, done arithmetically.
  function automatic logic [15:0] sx(input int value, input int width);
    int v;
    v = value;
    if (v >= (1 << (width - 1))) v = v - (1 << width);
    return v[15:0];
  endfunction

  // Reference decode written straight from the opcode table.
  task automatic ref_decode(input logic [15:0] inst);
    int op, rd, ra, rb, low8, low4, low12;
    int immsel;
    op    = int'(inst) / 4096;
    rd    = (int'(inst) / 256) % 16;
    ra    = (int'(inst) / 16) % 16;
    rb    = int'(inst) % 16;
    low8  = int'(inst) % 256;
    low4  = int'(inst) % 16;
    low12 = int'(inst) % 4096;
    e_seld  = rd[3:0];
    e_sela  = ra[3:0];
    e_selb  = rb[3:0];
    e_imm   = 16'h0000;
    e_regwe = 1'b1;
    immsel  = 0;
    case (op)
      5:  e_selb = 4'h0;
      8:  begin e_sela = rd[3:0]; e_imm = sx(low8, 8); immsel = 1; end
      9:  begin e_imm = sx(low8, 8); immsel = 1; end
      10: begin e_imm = 16'(low8 * 256); immsel = 1; end
      12: begin e_imm = sx(low4, 4); immsel = 1; end
      13: begin e_selb = rd[3:0]; e_imm = sx(low4, 4); immsel = 1; e_regwe = 1'b0; end
      14: begin e_imm = sx(low12, 12); immsel = 1; e_regwe = 1'b0; end
      15: e_regwe = 1'b0;
      default: ;
    endcase
    e_aluop = 5'(immsel * 16 + op);
  endtask

  // One clock edge: the model takes the inputs presented at the edge.
  task automatic tick();
    logic       r, en;
    logic [15:0] ins;
    r = I_Rst; en = I_En; ins = I_Inst;
    @(posedge I_Clk);
    #1;
    if (r) begin
      e_aluop = '0; e_sela = '0; e_selb = '0; e_seld = '0; e_imm = '0; e_regwe = 1'b0;
    end else if (en) begin
      ref_decode(ins);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk16({tag, ".aluop"}, 16'(O_Aluop), 16'(e_aluop));
    chk16({tag, ".sela"},  16'(O_SelA),  16'(e_sela));
    chk16({tag, ".selb"},  16'(O_SelB),  16'(e_selb));
    chk16({tag, ".seld"},  16'(O_SelD),  16'(e_seld));
    chk16({tag, ".imm"},   O_Imm,        e_imm);
    chk16({tag, ".regwe"}, 16'(O_Regwe), 16'(e_regwe));
  endtask

  initial begin
    // Reset with enable high: reset must win.
    I_Rst = 1'b1; I_En = 1'b1; I_Inst = 16'h1704;
    tick();
    check_all("reset");
    chk16("reset.regwe_lit", 16'(O_Regwe), 16'h0);

    // Disabled: outputs stay at zero.
    I_Rst = 1'b0; I_En = 1'b0;
    tick(); tick();
    check_all("idle_hold");

    // SUB 0x1704
    I_En = 1'b1;
    tick();
    check_all("sub");
    chk16("sub.aluop_lit", 16'(O_Aluop), 16'h01);
    chk16("sub.seld_lit",  16'(O_SelD),  16'h7);
    chk16("sub.selb_lit",  16'(O_SelB),  16'h4);

    // ADDI 0x83F0
    I_Inst = 16'h83F0;
    tick();
    check_all("addi");
    chk16("addi.aluop_lit", 16'(O_Aluop), 16'h18);
    chk16("addi.sela_lit",  16'(O_SelA),  16'h3);
    chk16("addi.imm_lit",   O_Imm,        16'hFFF0);

    // LUI 0xA512
    I_Inst = 16'hA512;
    tick();
    check_all("lui");
    chk16("lui.imm_lit",   O_Imm,        16'h1200);
    chk16("lui.aluop_lit", 16'(O_Aluop), 16'h1A);

    // ST 0xD52F
    I_Inst = 16'hD52F;
    tick();
    check_all("st");
    chk16("st.selb_lit", 16'(O_SelB), 16'h5);
    chk16("st.sela_lit", 16'(O_SelA), 16'h2);
    chk16("st.imm_lit",  O_Imm,       16'hFFFF);
    chk16("st.regwe_lit", 16'(O_Regwe), 16'h0);

    // JMP 0xE800, then hold while I_Inst changes with enable low
    I_Inst = 16'hE800;
    tick();
    check_all("jmp");
    chk16("jmp.imm_lit", O_Imm, 16'hF800);
    I_En = 1'b0; I_Inst = 16'h5ABC;
    tick();
    I_Inst = 16'h0123;
    tick();
    check_all("jmp_hold");
    chk16("jmp_hold.imm_lit", O_Imm, 16'hF800);

    // NOT and SYS corner opcodes
    I_En = 1'b1; I_Inst = 16'h5A3C;
    tick();
    check_all("not");
    I_Inst = 16'hF123;
    tick();
    check_all("sys");

    // Mid-stream reset with a valid instruction, then resume
    I_Rst = 1'b1; I_Inst = 16'h9C80;
    tick();
    check_all("midreset");
    I_Rst = 1'b0;
    tick();
    check_all("resume");
    chk16("resume.imm_lit", O_Imm, 16'hFF80);

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      I_Rst  = ($urandom_range(0, 24) == 0);
      I_En   = ($urandom_range(0, 3) != 0);
      I_Inst = 16'($urandom);
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
